step_tracker: RTL and testbench

- Receiving end of the step-pulse interface: consumes the square-wave step stream produced by the pulse generator (one step per rising edge).
- Derives the fitness-display statistics: total steps, steps in the last completed second, distance, high-activity seconds and an activity flag.
- Outputs are registered and feed the seven-segment display mux directly.

---
 rtl/step_tracker.sv | 174 +++++++++++++++++
 tb/tb_step_tracker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/step_tracker.sv
// Step-pulse receiver: synchronises the step stream and derives the display
// statistics (total, per-second rate, distance, high-activity seconds, activity).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no recent steps; waiting for the next step event
// S_ACTIVE| stepping; leaves after IDLE_SECS consecutive empty windows
module step_tracker #(
  parameter int unsigned TICKS_PER_SEC       = 100000000,
  parameter int unsigned STEP_MAX            = 9999,
  parameter int unsigned STEPS_PER_HALF_MILE = 1024,
  parameter int unsigned HIGH_RATE           = 32,
  parameter int unsigned IDLE_SECS           = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PULSE,
  output logic [13:0] TOTAL_STEPS,
  output logic [7:0]  STEP_RATE,
  output logic [5:0]  DISTANCE,
  output logic [7:0]  HIGH_ACT_SECS,
  output logic        ACTIVE,
  output logic        SATURATED
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int ZERO_W = (IDLE_SECS > 0) ? $clog2(IDLE_SECS + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [ZERO_W-1:0] IDLE_LAST  = ZERO_W'(IDLE_SECS);
  localparam logic [13:0]       STEP_MAX_C = 14'(STEP_MAX);
  localparam logic [10:0]       HALF_C     = 11'(STEPS_PER_HALF_MILE);
  localparam logic [8:0]        HIGH_C     = 9'(HIGH_RATE);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  logic              s1_q, s2_q, p_q;
  logic [2:0]        vld_q;
  logic              step_ev;

  state_t            state_q, state_d;
  logic [13:0]       total_q, total_d;
  logic [9:0]        sub_q, sub_d;
  logic [10:0]       sub_inc;
  logic [5:0]        dist_q, dist_d;
  logic              sat_q, sat_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick_end;
  logic [7:0]        win_q, win_d, win_inc;
  logic [7:0]        rate_q, rate_d;
  logic [7:0]        high_q, high_d;
  logic [ZERO_W-1:0] zero_q, zero_d;
  logic              active_q, active_d;

  // vld_q marks which synchroniser stages hold real samples of PULSE rather
  // than reset values, so a pulse already high at release is not an edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      p_q   <= 1'b0;
      vld_q <= 3'b000;
    end else begin
      s1_q  <= PULSE;
      s2_q  <= s1_q;
      p_q   <= s2_q;
      vld_q <= {vld_q[1:0], 1'b1};
    end
  end

  assign step_ev = s2_q & ~p_q & vld_q[2];

  always_comb begin
    total_d = total_q;
    sub_d   = sub_q;
    dist_d  = dist_q;
    sub_inc = {1'b0, sub_q} + 11'd1;
    if (step_ev && (total_q < STEP_MAX_C)) begin
      total_d = total_q + 14'd1;
      if (sub_inc == HALF_C) begin
        sub_d = 10'd0;
        if (dist_q != 6'd63) begin
          dist_d = dist_q + 6'd1;
        end
      end else begin
        sub_d = sub_inc[9:0];
      end
    end
    sat_d = sat_q | (total_d == STEP_MAX_C);
  end

  // A step on the window-end cycle folds into the closing window's rate.
  always_comb begin
    tick_end = (tick_q == TICK_LAST);
    tick_d   = tick_end ? '0 : tick_q + TICK_W'(1);
    win_inc  = (step_ev && (win_q != 8'hFF)) ? win_q + 8'd1 : win_q;
    win_d    = tick_end ? 8'd0 : win_inc;
    rate_d   = tick_end ? win_inc : rate_q;
    high_d   = high_q;
    if (tick_end && ({1'b0, win_inc} >= HIGH_C) && (high_q != 8'hFF)) begin
      high_d = high_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (step_ev) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (tick_end) begin
          if (win_inc == 8'd0) begin
            if ((zero_q + ZERO_W'(1)) == IDLE_LAST) begin
              state_d = S_IDLE;
              zero_d  = '0;
            end else begin
              zero_d = zero_q + ZERO_W'(1);
            end
          end else begin
            zero_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        zero_d  = '0;
      end
    endcase
    active_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      total_q  <= 14'd0;
      sub_q    <= 10'd0;
      dist_q   <= 6'd0;
      sat_q    <= 1'b0;
      tick_q   <= '0;
      win_q    <= 8'd0;
      rate_q   <= 8'd0;
      high_q   <= 8'd0;
      zero_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      sub_q    <= sub_d;
      dist_q   <= dist_d;
      sat_q    <= sat_d;
      tick_q   <= tick_d;
      win_q    <= win_d;
      rate_q   <= rate_d;
      high_q   <= high_d;
      zero_q   <= zero_d;
      active_q <= active_d;
    end
  end

  assign TOTAL_STEPS   = total_q;
  assign STEP_RATE     = rate_q;
  assign DISTANCE      = dist_q;
  assign HIGH_ACT_SECS = high_q;
  assign ACTIVE        = active_q;
  assign SATURATED     = sat_q;

endmodule

// File: tb/tb_step_tracker.sv
// Directed bench for step_tracker: small window, low thresholds, and
// hand-computed expectations at fixed clock-edge counts after each reset release.
module tb_step_tracker;

  logic        CLK;
  logic        RESET_N;
  logic        PULSE;
  logic [13:0] TOTAL_STEPS;
  logic [7:0]  STEP_RATE;
  logic [5:0]  DISTANCE;
  logic [7:0]  HIGH_ACT_SECS;
  logic        ACTIVE;
  logic        SATURATED;

  int tests = 0;
  int fails = 0;
  int edges = 0;

  step_tracker #(
    .TICKS_PER_SEC      (100),
    .STEP_MAX           (10),
    .STEPS_PER_HALF_MILE(4),
    .HIGH_RATE          (4),
    .IDLE_SECS          (3)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .PULSE        (PULSE),
    .TOTAL_STEPS  (TOTAL_STEPS),
    .STEP_RATE    (STEP_RATE),
    .DISTANCE     (DISTANCE),
    .HIGH_ACT_SECS(HIGH_ACT_SECS),
    .ACTIVE       (ACTIVE),
    .SATURATED    (SATURATED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    edges++;
    #1;
  endtask

  task automatic to_edge(input int n);
    while (edges < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_total"}, 32'(TOTAL_STEPS), 0);
    check({tag, "_rate"},  32'(STEP_RATE), 0);
    check({tag, "_dist"},  32'(DISTANCE), 0);
    check({tag, "_high"},  32'(HIGH_ACT_SECS), 0);
    check({tag, "_active"}, 32'(ACTIVE), 0);
    check({tag, "_sat"},   32'(SATURATED), 0);
  endtask

  task automatic release_reset();
    RESET_N = 1'b1;
    edges   = 0;
  endtask

  task automatic pulse_at(input int start);
    to_edge(start);
    PULSE = 1'b1;
    to_edge(start + 5);
    PULSE = 1'b0;
    to_edge(start + 10);
  endtask

  initial begin
    RESET_N = 1'b0;
    PULSE   = 1'b0;

    // 1: reset holds everything at zero while PULSE toggles
    for (int i = 0; i < 6; i++) begin
      PULSE = ~PULSE;
      tick();
    end
    check_zero("t1_reset");
    release_reset();
    to_edge(5);
    PULSE = 1'b1;
    to_edge(7);
    check("t1_total_e7", 32'(TOTAL_STEPS), 0);
    check("t1_active_e7", 32'(ACTIVE), 0);
    to_edge(8);
    check("t1_total_e8", 32'(TOTAL_STEPS), 1);
    check("t1_active_e8", 32'(ACTIVE), 1);
    to_edge(9);
    PULSE = 1'b0;

    // 2: 5 steps in window 1, 3 in window 2
    RESET_N = 1'b0;
    tick();
    tick();
    release_reset();
    for (int k = 1; k <= 5; k++) pulse_at(10 * k);
    to_edge(99);
    check("t2_rate_e99", 32'(STEP_RATE), 0);
    check("t2_total_e99", 32'(TOTAL_STEPS), 5);
    to_edge(100);
    check("t2_rate_w1", 32'(STEP_RATE), 5);
    check("t2_high_w1", 32'(HIGH_ACT_SECS), 1);
    for (int k = 11; k <= 13; k++) pulse_at(10 * k);
    to_edge(200);
    check("t2_rate_w2", 32'(STEP_RATE), 3);
    check("t2_high_w2", 32'(HIGH_ACT_SECS), 1);
    check("t2_total_w2", 32'(TOTAL_STEPS), 8);
    check("t2_dist_w2", 32'(DISTANCE), 2);
    check("t2_active_w2", 32'(ACTIVE), 1);

    // 3: 3 steps plus one whose event lands on tick 99 (total saturates meanwhile)
    for (int k = 21; k <= 23; k++) pulse_at(10 * k);
    to_edge(297);
    PULSE = 1'b1;
    to_edge(299);
    check("t3_rate_e299", 32'(STEP_RATE), 3);
    check("t3_total_e299", 32'(TOTAL_STEPS), 10);
    to_edge(300);
    check("t3_rate_w3", 32'(STEP_RATE), 4);
    check("t3_high_w3", 32'(HIGH_ACT_SECS), 2);
    check("t3_sat_w3", 32'(SATURATED), 1);
    check("t3_dist_w3", 32'(DISTANCE), 2);
    to_edge(302);
    PULSE = 1'b0;
    to_edge(400);
    check("t3_rate_w4", 32'(STEP_RATE), 0);
    check("t3_high_w4", 32'(HIGH_ACT_SECS), 2);
    check("t3_active_w4", 32'(ACTIVE), 1);

    // 4: distance and saturation
    RESET_N = 1'b0;
    #1;
    check("t4_reset_total", 32'(TOTAL_STEPS), 0);
    check("t4_reset_sat", 32'(SATURATED), 0);
    tick();
    tick();
    release_reset();
    for (int k = 1; k <= 4; k++) pulse_at(10 * k);
    check("t4_dist_4", 32'(DISTANCE), 1);
    check("t4_total_4", 32'(TOTAL_STEPS), 4);
    for (int k = 5; k <= 9; k++) pulse_at(10 * k);
    check("t4_total_9", 32'(TOTAL_STEPS), 9);
    check("t4_sat_9", 32'(SATURATED), 0);
    check("t4_dist_9", 32'(DISTANCE), 2);
    check("t4_rate_w1", 32'(STEP_RATE), 9);
    check("t4_high_w1", 32'(HIGH_ACT_SECS), 1);
    for (int k = 10; k <= 12; k++) pulse_at(10 * k);
    check("t4_total_12", 32'(TOTAL_STEPS), 10);
    check("t4_sat_12", 32'(SATURATED), 1);
    check("t4_dist_12", 32'(DISTANCE), 2);

    // 5: three empty windows return to idle; one more step re-activates
    to_edge(200);
    check("t5_rate_w2", 32'(STEP_RATE), 3);
    to_edge(400);
    check("t5_active_w4", 32'(ACTIVE), 1);
    to_edge(499);
    check("t5_active_e499", 32'(ACTIVE), 1);
    to_edge(500);
    check("t5_active_e500", 32'(ACTIVE), 0);
    check("t5_total_e500", 32'(TOTAL_STEPS), 10);
    check("t5_rate_e500", 32'(STEP_RATE), 0);
    to_edge(510);
    PULSE = 1'b1;
    to_edge(512);
    check("t5_active_e512", 32'(ACTIVE), 0);
    to_edge(513);
    check("t5_active_e513", 32'(ACTIVE), 1);
    to_edge(515);
    PULSE = 1'b0;

    // 6: reset mid-window with PULSE held high
    to_edge(520);
    PULSE = 1'b1;
    to_edge(525);
    RESET_N = 1'b0;
    #1;
    check_zero("t6_async");
    tick();
    tick();
    tick();
    release_reset();
    to_edge(6);
    check("t6_total_held", 32'(TOTAL_STEPS), 0);
    check("t6_active_held", 32'(ACTIVE), 0);
    check("t6_rate_held", 32'(STEP_RATE), 0);
    PULSE = 1'b0;
    to_edge(10);
    PULSE = 1'b1;
    to_edge(12);
    check("t6_total_e12", 32'(TOTAL_STEPS), 0);
    to_edge(13);
    check("t6_total_e13", 32'(TOTAL_STEPS), 1);
    check("t6_active_e13", 32'(ACTIVE), 1);
    to_edge(16);
    PULSE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
